// File: rtl/sha_core_sched.sv
// Schedules message blocks from NREQ requesters onto one shared sha_core and returns tagged
// per-block digests. Chained blocks land exactly 64 cycles apart; fresh messages wait for the core.
module sha_core_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ-1:0]       req_redo,
  input  logic [NREQ*512-1:0]   req_block,
  output logic                  core_in_valid,
  output logic                  core_redo,
  output logic [511:0]          core_message,
  input  logic                  core_out_valid,
  input  logic [255:0]          core_hash,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_last,
  output logic                  rsp_abort,
  output logic [255:0]          rsp_hash,
  output logic                  err
);

  localparam logic [6:0] FlushLast = 7'd65;
  localparam logic [6:0] ChainSlot = 7'd63;

  typedef enum logic [1:0] {StFlush, StIdle, StRun, StDrain} state_e;

  state_e         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic           last_q, last_d;
  logic           abort_q, abort_d;

  logic [IDW-1:0] gnt, idx, sel_id;
  logic           gnt_found;
  logic [511:0]   sel_block;
  logic           sel_valid, sel_last, sel_redo;
  logic           issue, pop;

  // In-flight tags; two entries cover the chained overlap of issue N+1 and return of N.
  logic [IDW-1:0] fid_q [2];
  logic [1:0]     flast_q;
  logic           wr_q, rd_q;
  logic [1:0]     fcnt_q;
  logic [6:0]     gap_q;

  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IDW'((32'(rr_ptr_q) + off) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
  end

  assign sel_id = (state_q == StIdle) ? gnt : owner_q;

  always_comb begin
    sel_block = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_redo  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == IDW'(i)) begin
        sel_block = req_block[i*512 +: 512];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_redo  = req_redo[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    last_d       = last_q;
    abort_d      = abort_q;
    issue        = 1'b0;
    err          = 1'b0;
    core_message = '0;
    core_redo    = 1'b0;
    case (state_q)
      StFlush: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == FlushLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: issue = gnt_found;
      StRun: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == ChainSlot) begin
          if (sel_valid) begin
            issue = 1'b1;
          end else begin
            err     = 1'b1;
            abort_d = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave only when the last outstanding block returns, not an older chained one.
        if (core_out_valid && fcnt_q == 2'd1) state_d = StIdle;
      end
      default: state_d = StFlush;
    endcase

    if (issue) begin
      core_message = sel_block;
      core_redo    = sel_redo & ~sel_last;
      owner_d      = sel_id;
      last_d       = sel_last;
      cnt_d        = '0;
      state_d      = sel_last ? StDrain : StRun;
      if (state_q == StIdle) begin
        abort_d  = 1'b0;
        rr_ptr_d = (32'(sel_id) == NREQ - 1) ? '0 : sel_id + 1'b1;
      end
    end

    core_in_valid = issue;
    if (reset) begin
      core_in_valid = 1'b0;
      core_message  = '0;
      core_redo     = 1'b0;
      err           = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = core_in_valid && (sel_id == IDW'(i));
    end
  end

  assign pop = core_out_valid && (state_q != StFlush) && (fcnt_q != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFlush;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      last_q    <= 1'b0;
      abort_q   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      fcnt_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
      rsp_abort <= 1'b0;
      rsp_hash  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      if (issue) wr_q <= ~wr_q;
      if (pop)   rd_q <= ~rd_q;
      fcnt_q    <= fcnt_q + {1'b0, issue} - {1'b0, pop};
      rsp_valid <= pop;
      if (pop) begin
        rsp_id    <= fid_q[rd_q];
        rsp_last  <= flast_q[rd_q] & ~abort_q;
        rsp_abort <= abort_q;
        rsp_hash  <= core_hash;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue && !reset) begin
      fid_q[wr_q]   <= sel_id;
      flast_q[wr_q] <= sel_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= 7'h7f;
    end else if (core_in_valid) begin
      gap_q <= '0;
    end else if (gap_q != 7'h7f) begin
      gap_q <= gap_q + 7'd1;
    end
    if (!reset && core_in_valid) begin
      if (state_q == StRun) assert (gap_q == 7'd63);
      else assert (gap_q >= 7'd64);
      assert (!(fcnt_q == 2'd2 && !pop));
    end
  end

endmodule
